jk_excitation_driver: RTL

- Drive side for a bank of WIDTH JK flip-flops: takes target register values and generates the J/K excitation that moves the bank to each value.
- Buffers targets in a small FIFO and keeps a shadow model of the bank state.
- Checks the bank's fed-back Q against the model after every step and flags divergence.
- Sits between a test or sequence source and a JKff register bank that shares its clock.

---
 rtl/jk_excitation_driver.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/jk_excitation_driver.sv
// Drive side for a bank of JK flip-flops: FIFO-buffered targets, J/K excitation, shadow-model check.
// Optional build macro JK_TOGGLE_PREF_EN: changing bits are excited with J=K=1 (toggle) instead of set/reset.
module jk_excitation_driver #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             drv_valid,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] q_model,
  output logic             busy,
  output logic             mismatch,
  output logic [7:0]       err_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full_q;

  logic             push_c;
  logic             pop_c;
  logic [WIDTH-1:0] head_c;
  logic [WIDTH-1:0] diff_c;
  logic [WIDTH-1:0] exc_j_c;
  logic [WIDTH-1:0] exc_k_c;
  logic [WIDTH-1:0] q_next_c;

  // Ready is taken from the registered full flag, so a same-edge pop never frees a slot early.
  assign tgt_ready = !full_q;
  assign busy      = (state != IDLE) || (count != '0);

  assign push_c = tgt_valid && !full_q;
  assign pop_c  = (state == IDLE) && (count != '0);
  assign head_c = mem[rd_ptr];
  assign diff_c = head_c ^ q_model;

  // Unchanged bits are always held with J=K=0.
`ifdef JK_TOGGLE_PREF_EN
  assign exc_j_c = diff_c;
  assign exc_k_c = diff_c;
`else
  assign exc_j_c = diff_c & head_c;
  assign exc_k_c = diff_c & ~head_c;
`endif

  // Characteristic JK equation applied to the excitation currently on the bank.
  assign q_next_c = (j_out & ~q_model) | (~k_out & q_model);

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= tgt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full_q    <= 1'b0;
      j_out     <= '0;
      k_out     <= '0;
      drv_valid <= 1'b0;
      q_model   <= '0;
      mismatch  <= 1'b0;
      err_count <= 8'd0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_c && !pop_c) begin
        count  <= count + CW'(1);
        full_q <= (count == CW'(DEPTH - 1));
      end else if (!push_c && pop_c) begin
        count  <= count - CW'(1);
        full_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pop_c) begin
            j_out     <= exc_j_c;
            k_out     <= exc_k_c;
            drv_valid <= 1'b1;
            state     <= DRIVE;
          end else begin
            j_out     <= '0;
            k_out     <= '0;
            drv_valid <= 1'b0;
          end
        end
        DRIVE: begin
          q_model   <= q_next_c;
          j_out     <= '0;
          k_out     <= '0;
          drv_valid <= 1'b0;
          state     <= CHECK;
        end
        CHECK: begin
          // The bank captured on the edge that left DRIVE, so q_fb is settled here.
          if (q_fb != q_model) begin
            mismatch <= 1'b1;
            if (err_count != 8'hFF) begin
              err_count <= err_count + 8'd1;
            end
          end
          state <= IDLE;
        end
        default: begin
          j_out     <= '0;
          k_out     <= '0;
          drv_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
